// File: rtl/issue_select.sv
// Issue select: picks up to N operand-ready RS entries per cycle with rotating
// priority and per-FU-class limits, and registers them compacted for execute.
module issue_select #(
   parameter int RS_SZ    = 16,
   parameter int N        = 3,
   parameter int NUM_ALU  = 3,
   parameter int NUM_MULT = 1,
   parameter int NUM_BR   = 1,
   parameter int NUM_MEM  = 1,
   parameter int B_MASK_W = 4,
   parameter int TAG_W    = 8,
   localparam int PKT_W   = TAG_W + 2 + B_MASK_W + 2,
   localparam int IDX_W   = $clog2(RS_SZ)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [RS_SZ-1:0][PKT_W-1:0]    RS_data,
   input  logic [RS_SZ-1:0]               RS_valid_next,
   input  logic [NUM_ALU-1:0]             fu_free_alu,
   input  logic [NUM_MULT-1:0]            fu_free_mult,
   input  logic [NUM_BR-1:0]              fu_free_br,
   input  logic [NUM_MEM-1:0]             fu_free_mem,
   input  logic [B_MASK_W-1:0]            b_mm_resolve,
   input  logic                           b_mm_mispred,
   output logic [RS_SZ-1:0]               rs_data_issuing,
   output logic [N-1:0][PKT_W-1:0]        issue_packets,
   output logic [N-1:0]                   issue_valid
);

   localparam int CNT_W  = $clog2(RS_SZ + 1);
   localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      FU_ALU  = 2'd0,
      FU_MULT = 2'd1,
      FU_BR   = 2'd2,
      FU_MEM  = 2'd3
   } fu_type_e;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      fu_type_e            fu_type;
      logic [B_MASK_W-1:0] b_mask;
      logic                src2_ready;
      logic                src1_ready;
   } rs_packet_t;

   logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic [N-1:0]               issue_valid_q, issue_valid_d;
   logic [N-1:0][PKT_W-1:0]    issue_packets_q, issue_packets_d;

   logic [RS_SZ-1:0]           eligible;
   logic [RS_SZ-1:0]           sel_vec;
   logic [CNT_W-1:0]           free_alu, free_mult, free_br, free_mem;
   logic [CNT_W-1:0]           cnt_alu, cnt_mult, cnt_br, cnt_mem, total;
   logic [IDX_W-1:0]           idx, last_idx;
   logic                       any_sel, take;
   rs_packet_t                 pkt;

   assign free_alu  = CNT_W'($countones(fu_free_alu));
   assign free_mult = CNT_W'($countones(fu_free_mult));
   assign free_br   = CNT_W'($countones(fu_free_br));
   assign free_mem  = CNT_W'($countones(fu_free_mem));

   // Entries squashed by a mispredicting branch are never eligible
   always_comb begin
      eligible = '0;
      for (int i = 0; i < RS_SZ; i++) begin
         rs_packet_t p;
         p = rs_packet_t'(RS_data[i]);
         eligible[i] = RS_valid_next[i] & p.src1_ready & p.src2_ready &
                       ~(b_mm_mispred & (|(p.b_mask & b_mm_resolve)));
      end
   end

   always_comb begin
      sel_vec         = '0;
      issue_valid_d   = '0;
      issue_packets_d = '0;
      cnt_alu         = '0;
      cnt_mult        = '0;
      cnt_br          = '0;
      cnt_mem         = '0;
      total           = '0;
      last_idx        = rr_ptr_q;
      any_sel         = 1'b0;
      idx             = '0;
      take            = 1'b0;
      pkt             = '0;
      for (int k = 0; k < RS_SZ; k++) begin
         idx  = IDX_W'((int'(rr_ptr_q) + k) % RS_SZ);
         pkt  = rs_packet_t'(RS_data[idx]);
         take = 1'b0;
         if (eligible[idx] && (total < CNT_W'(N))) begin
            unique case (pkt.fu_type)
               FU_ALU:  take = cnt_alu  < free_alu;
               FU_MULT: take = cnt_mult < free_mult;
               FU_BR:   take = cnt_br   < free_br;
               FU_MEM:  take = cnt_mem  < free_mem;
               default: take = 1'b0;
            endcase
         end
         if (take) begin
            unique case (pkt.fu_type)
               FU_ALU:  cnt_alu  = cnt_alu  + 1'b1;
               FU_MULT: cnt_mult = cnt_mult + 1'b1;
               FU_BR:   cnt_br   = cnt_br   + 1'b1;
               FU_MEM:  cnt_mem  = cnt_mem  + 1'b1;
               default: ;
            endcase
            // A correctly resolved branch no longer needs tracking in the issued op
            if (!b_mm_mispred) begin
               pkt.b_mask = pkt.b_mask & ~b_mm_resolve;
            end
            sel_vec[idx]                        = 1'b1;
            issue_valid_d[total[SLOT_W-1:0]]   = 1'b1;
            issue_packets_d[total[SLOT_W-1:0]] = pkt;
            total                               = total + 1'b1;
            last_idx                            = idx;
            any_sel                             = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (any_sel) begin
         rr_ptr_d = (last_idx == IDX_W'(RS_SZ - 1)) ? '0 : last_idx + 1'b1;
      end
   end

   assign rs_data_issuing = reset ? '0 : sel_vec;

   // Issue register is rewritten every cycle; reset discards in-flight selections
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q        <= '0;
         issue_valid_q   <= '0;
         issue_packets_q <= '0;
      end else begin
         rr_ptr_q        <= rr_ptr_d;
         issue_valid_q   <= issue_valid_d;
         issue_packets_q <= issue_packets_d;
      end
   end

   assign issue_valid   = issue_valid_q;
   assign issue_packets = issue_packets_q;

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed scenarios plus a random run, with a
// reference model feeding a scoreboard of expected issue-register contents.
module tb_issue_select;

   localparam int RS_SZ = 16;
   localparam int N     = 3;
   localparam int PKT_W = 16;

   logic                        clock = 1'b0;
   logic                        reset;
   logic [RS_SZ-1:0][PKT_W-1:0] RS_data;
   logic [RS_SZ-1:0]            RS_valid_next;
   logic [2:0]                  fu_free_alu;
   logic [0:0]                  fu_free_mult, fu_free_br, fu_free_mem;
   logic [3:0]                  b_mm_resolve;
   logic                        b_mm_mispred;
   logic [RS_SZ-1:0]            rs_data_issuing;
   logic [N-1:0][PKT_W-1:0]     issue_packets;
   logic [N-1:0]                issue_valid;

   typedef struct {
      logic [N-1:0]            vld;
      logic [N-1:0][PKT_W-1:0] pkt;
      logic [3:0]              rr;
   } exp_t;

   exp_t             sbQ[$];
   int               mdlRr = 0;
   int               passCount = 0;
   int               checkCount = 0;
   logic [RS_SZ-1:0] lastIss;

   issue_select dut (
      .clock           (clock),
      .reset           (reset),
      .RS_data         (RS_data),
      .RS_valid_next   (RS_valid_next),
      .fu_free_alu     (fu_free_alu),
      .fu_free_mult    (fu_free_mult),
      .fu_free_br      (fu_free_br),
      .fu_free_mem     (fu_free_mem),
      .b_mm_resolve    (b_mm_resolve),
      .b_mm_mispred    (b_mm_mispred),
      .rs_data_issuing (rs_data_issuing),
      .issue_packets   (issue_packets),
      .issue_valid     (issue_valid)
   );

   always #5 clock = ~clock;

   // Packet layout: {tag[7:0], fu[1:0], b_mask[3:0], src2_ready, src1_ready}
   function automatic logic [PKT_W-1:0] mk(input int idx, input logic [1:0] fu,
                                           input logic [3:0] bm, input logic r1, input logic r2);
      logic [7:0] tag;
      tag = 8'(idx + 8'h40);
      return {tag, fu, bm, r2, r1};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic modelStep(output logic [RS_SZ-1:0] iss, output exp_t e);
      int               budget[4];
      int               used;
      int               i;
      logic [PKT_W-1:0] p;
      logic             elig;
      iss   = '0;
      e.vld = '0;
      e.pkt = '0;
      e.rr  = 4'(mdlRr);
      if (reset) begin
         e.rr = 4'd0;
         return;
      end
      budget[0] = $countones(fu_free_alu);
      budget[1] = $countones(fu_free_mult);
      budget[2] = $countones(fu_free_br);
      budget[3] = $countones(fu_free_mem);
      used = 0;
      for (int k = 0; k < RS_SZ; k++) begin
         i    = (mdlRr + k) % RS_SZ;
         p    = RS_data[i];
         elig = RS_valid_next[i] && p[0] && p[1] && !(b_mm_mispred && |(p[5:2] & b_mm_resolve));
         if (elig && used < N && budget[p[7:6]] > 0) begin
            budget[p[7:6]]--;
            iss[i] = 1'b1;
            if (!b_mm_mispred) p[5:2] = p[5:2] & ~b_mm_resolve;
            e.pkt[used] = p;
            e.vld[used] = 1'b1;
            used++;
            e.rr = 4'((i + 1) % RS_SZ);
         end
      end
   endtask

   // Check the combinational selection, then the registered result one edge later
   task automatic applyStimulus();
      exp_t             e;
      logic [RS_SZ-1:0] iss;
      logic [RS_SZ-1:0] readyMask;
      #1;
      modelStep(iss, e);
      readyMask = '0;
      for (int i = 0; i < RS_SZ; i++)
         readyMask[i] = RS_valid_next[i] & RS_data[i][0] & RS_data[i][1];
      lastIss = rs_data_issuing;
      checkOutput("issuing", rs_data_issuing, iss);
      checkOutput("issCount", 64'($countones(rs_data_issuing) <= N), 64'd1);
      checkOutput("issReady", rs_data_issuing & ~readyMask, 0);
      sbQ.push_back(e);
      @(posedge clock);
      #1;
      e     = sbQ.pop_front();
      mdlRr = e.rr;
      checkOutput("valid", issue_valid, e.vld);
      for (int s = 0; s < N; s++)
         if (e.vld[s]) checkOutput("slotPkt", issue_packets[s], e.pkt[s]);
      checkOutput("rrPtr", dut.rr_ptr_q, e.rr);
   endtask

   task automatic clearRs();
      RS_valid_next = '0;
      for (int i = 0; i < RS_SZ; i++) RS_data[i] = mk(i, 2'd0, 4'd0, 1'b0, 1'b0);
      b_mm_resolve = '0;
      b_mm_mispred = 1'b0;
      fu_free_alu  = 3'b111;
      fu_free_mult = 1'b1;
      fu_free_br   = 1'b1;
      fu_free_mem  = 1'b1;
   endtask

   task automatic setEntry(input int i, input logic [1:0] fu, input logic [3:0] bm,
                           input logic r1, input logic r2);
      RS_data[i]       = mk(i, fu, bm, r1, r2);
      RS_valid_next[i] = 1'b1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clearRs();
      for (int i = 0; i < RS_SZ; i++) setEntry(i, 2'd0, 4'd0, 1'b1, 1'b1);
      applyStimulus();
      applyStimulus();
      checkOutput("rstIss", lastIss, 0);
      checkOutput("rstValid", issue_valid, 0);
      checkOutput("rstPkts", issue_packets, 0);
      checkOutput("rstRr", dut.rr_ptr_q, 0);
      reset = 1'b0;

      clearRs();
      setEntry(2, 2'd0, 4'd0, 1'b1, 1'b1);
      setEntry(5, 2'd0, 4'd0, 1'b1, 1'b1);
      setEntry(3, 2'd0, 4'd0, 1'b1, 1'b0);
      setEntry(7, 2'd0, 4'd0, 1'b0, 1'b1);
      applyStimulus();
      checkOutput("t2Iss", lastIss, 16'h0024);
      checkOutput("t2Valid", issue_valid, 3'b011);
      checkOutput("t2Slot0", issue_packets[0], mk(2, 2'd0, 4'd0, 1'b1, 1'b1));
      checkOutput("t2Slot1", issue_packets[1], mk(5, 2'd0, 4'd0, 1'b1, 1'b1));

      clearRs();
      doReset();
      setEntry(1, 2'd1, 4'd0, 1'b1, 1'b1);
      setEntry(4, 2'd1, 4'd0, 1'b1, 1'b1);
      setEntry(9, 2'd1, 4'd0, 1'b1, 1'b1);
      applyStimulus();
      checkOutput("t3Iss", lastIss, 16'h0002);
      checkOutput("t3Rr", dut.rr_ptr_q, 2);
      RS_valid_next[1] = 1'b0;
      applyStimulus();
      checkOutput("t3Next", lastIss, 16'h0010);

      clearRs();
      doReset();
      setEntry(13, 2'd0, 4'd0, 1'b1, 1'b1);
      applyStimulus();
      checkOutput("t4Rr14", dut.rr_ptr_q, 14);
      clearRs();
      setEntry(0, 2'd0, 4'd0, 1'b1, 1'b1);
      setEntry(1, 2'd0, 4'd0, 1'b1, 1'b1);
      setEntry(15, 2'd0, 4'd0, 1'b1, 1'b1);
      applyStimulus();
      checkOutput("t4Iss", lastIss, 16'h8003);
      checkOutput("t4Valid", issue_valid, 3'b111);
      checkOutput("t4Slot0", issue_packets[0], mk(15, 2'd0, 4'd0, 1'b1, 1'b1));
      checkOutput("t4Rr", dut.rr_ptr_q, 2);

      clearRs();
      doReset();
      setEntry(3, 2'd0, 4'b0010, 1'b1, 1'b1);
      applyStimulus();
      checkOutput("t5Held", issue_valid, 3'b001);
      clearRs();
      setEntry(6, 2'd0, 4'b0010, 1'b1, 1'b1);
      b_mm_resolve = 4'b0010;
      b_mm_mispred = 1'b1;
      applyStimulus();
      checkOutput("t5Iss", lastIss, 0);
      checkOutput("t5Valid", issue_valid, 0);

      clearRs();
      setEntry(9, 2'd0, 4'b0010, 1'b1, 1'b1);
      b_mm_resolve = 4'b0010;
      applyStimulus();
      checkOutput("t6Valid", issue_valid, 3'b001);
      checkOutput("t6Mask", issue_packets[0][5:2], 0);

      for (int c = 0; c < 10000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < RS_SZ; i++)
            RS_data[i] = mk(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
         RS_valid_next = 16'($urandom);
         fu_free_alu   = 3'($urandom);
         fu_free_mult  = 1'($urandom);
         fu_free_br    = 1'($urandom);
         fu_free_mem   = 1'($urandom);
         b_mm_resolve  = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
         b_mm_mispred  = 1'($urandom);
         applyStimulus();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
